// File: rtl/visca_pkg.sv
// Shared definitions for the VISCA command sequencer: command ids, packet byte
// constants, status codes, FSM state encodings and header helpers.
package visca_pkg;

    // Command ids accepted on cmd_id.
    localparam logic [2:0] CMD_ZOOM_STOP     = 3'd0;
    localparam logic [2:0] CMD_ZOOM_TELE     = 3'd1;
    localparam logic [2:0] CMD_ZOOM_WIDE     = 3'd2;
    localparam logic [2:0] CMD_ZOOM_TELE_VAR = 3'd3;
    localparam logic [2:0] CMD_ZOOM_WIDE_VAR = 3'd4;
    localparam logic [2:0] CMD_FOCUS_STOP    = 3'd5;
    localparam logic [2:0] CMD_FOCUS_FAR     = 3'd6;
    localparam logic [2:0] CMD_FOCUS_NEAR    = 3'd7;

    // Fixed packet bytes.
    localparam logic [7:0] BYTE_CMD    = 8'h01;
    localparam logic [7:0] BYTE_CAT_IF = 8'h04;
    localparam logic [7:0] BYTE_ZOOM   = 8'h07;
    localparam logic [7:0] BYTE_FOCUS  = 8'h08;
    localparam logic [7:0] BYTE_TERM   = 8'hFF;

    // Argument byte values for the fixed-speed commands.
    localparam logic [7:0] ARG_STOP      = 8'h00;
    localparam logic [7:0] ARG_TELE_FAR  = 8'h02;
    localparam logic [7:0] ARG_WIDE_NEAR = 8'h03;

    // Index of the terminator byte; every packet is six bytes long.
    localparam logic [2:0] LAST_IDX = 3'd5;

    // Completion status codes.
    localparam logic [1:0] STATUS_OK      = 2'd0;
    localparam logic [1:0] STATUS_ERR     = 2'd1;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_REPLY,
        ST_FIN
    } state_e;

    // Position inside an incoming reply frame.
    typedef enum logic [1:0] {
        RX_HDR,
        RX_TYPE,
        RX_TAIL,
        RX_SKIP
    } rx_pos_e;

    // Command header: 8'h8x with x = camera address.
    function automatic logic [7:0] cmd_header(input int unsigned addr);
        return 8'h80 | 8'(addr & 32'd7);
    endfunction

    // Reply header: 8'h80 | ((addr + 8) << 4), truncated to a byte.
    function automatic logic [7:0] reply_header(input int unsigned addr);
        return 8'h80 | 8'((addr + 32'd8) << 4);
    endfunction

endpackage

// File: rtl/visca_pkt_rom.sv
// Combinational packet table: (command, speed, byte index) -> packet byte.
module visca_pkt_rom
    import visca_pkg::*;
#(
    parameter int unsigned CAM_ADDR = 1
) (
    input  logic [2:0] cmd_id,
    input  logic [2:0] speed,
    input  logic [2:0] idx,
    output logic [7:0] pkt_byte
);

    logic [7:0] arg_byte;

    // Argument byte (byte 4): fixed code or speed-carrying code.
    always_comb begin
        // NOTE: default assigned first so no path leaves it unassigned (no latch).
        arg_byte = ARG_STOP;
        case (cmd_id)
            CMD_ZOOM_TELE, CMD_FOCUS_FAR:   arg_byte = ARG_TELE_FAR;
            CMD_ZOOM_WIDE, CMD_FOCUS_NEAR:  arg_byte = ARG_WIDE_NEAR;
            CMD_ZOOM_TELE_VAR:              arg_byte = {4'h2, 1'b0, speed};
            CMD_ZOOM_WIDE_VAR:              arg_byte = {4'h3, 1'b0, speed};
            default:                        arg_byte = ARG_STOP;
        endcase
    end

    // Byte select by index; indices 6 and 7 never occur.
    always_comb begin
        pkt_byte = 8'h00;
        case (idx)
            3'd0:    pkt_byte = cmd_header(CAM_ADDR);
            3'd1:    pkt_byte = BYTE_CMD;
            3'd2:    pkt_byte = BYTE_CAT_IF;
            3'd3:    pkt_byte = (cmd_id >= CMD_FOCUS_STOP) ? BYTE_FOCUS : BYTE_ZOOM;
            3'd4:    pkt_byte = arg_byte;
            3'd5:    pkt_byte = BYTE_TERM;
            default: pkt_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/visca_cmd_seq.sv
// VISCA command sequencer: accepts a command, streams its 6-byte packet to the
// UART TX over valid/ready, then pulses done with a status code.
// Build option VISCA_REPLY_WAIT_EN: wait for the camera reply (ACK/completion/
// error) with a timeout before finishing; otherwise finish right after byte 5.
module visca_cmd_seq
    import visca_pkg::*;
#(
    parameter int unsigned CAM_ADDR    = 1,
    parameter int unsigned TIMEOUT_CYC = 27_000_000,
    parameter int unsigned TO_W        = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_id,
    input  logic [3:0] cmd_speed,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic [1:0] status
);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] cmd_q, cmd_d;
    logic [2:0] spd_q, spd_d;
    logic [1:0] status_q, status_d;
    logic [7:0] rom_byte;

`ifdef VISCA_REPLY_WAIT_EN
    localparam logic [7:0]      REPLY_HDR = reply_header(CAM_ADDR);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    rx_pos_e         rx_pos_q, rx_pos_d;
    logic            rx_err_q, rx_err_d;
`else
    // Reply path and timeout settings have no function in this build.
    logic                     unused_rx;
    localparam int unsigned   UNUSED_TO = TIMEOUT_CYC + TO_W;
    assign unused_rx = ^{rx_data, rx_valid};
`endif

    visca_pkt_rom #(.CAM_ADDR(CAM_ADDR)) u_rom (
        .cmd_id   (cmd_q),
        .speed    (spd_q),
        .idx      (idx_q),
        .pkt_byte (rom_byte)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = !cmd_ready;
    assign tx_valid  = (state_q == ST_SEND);
    assign tx_data   = tx_valid ? rom_byte : 8'h00;
    assign done      = (state_q == ST_FIN);
    assign status    = status_q;

    // Next-state logic: accept, stream packet, optionally await reply, finish.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cmd_d    = cmd_q;
        spd_d    = spd_q;
        status_d = status_q;
`ifdef VISCA_REPLY_WAIT_EN
        to_cnt_d = to_cnt_q;
        rx_pos_d = rx_pos_q;
        rx_err_d = rx_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d    = cmd_id;
                    spd_d    = (cmd_speed > 4'd7) ? 3'd7 : cmd_speed[2:0];
                    status_d = STATUS_OK;
                    idx_d    = 3'd0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = 3'd0;
`ifdef VISCA_REPLY_WAIT_EN
                        state_d  = ST_WAIT_REPLY;
                        to_cnt_d = '0;
                        rx_pos_d = RX_HDR;
                        rx_err_d = 1'b0;
`else
                        state_d = ST_FIN;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef VISCA_REPLY_WAIT_EN
            ST_WAIT_REPLY: begin
                // Timeout first so a reply byte in the same cycle overrides it.
                if (to_cnt_q == TO_LAST) begin
                    state_d  = ST_FIN;
                    status_d = STATUS_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                if (rx_valid) begin
                    case (rx_pos_q)
                        RX_HDR: begin
                            if (rx_data == REPLY_HDR)
                                rx_pos_d = RX_TYPE;
                            else if (rx_data != BYTE_TERM)
                                rx_pos_d = RX_SKIP;
                        end
                        RX_TYPE: begin
                            rx_pos_d = RX_TAIL;
                            rx_err_d = 1'b0;
                            case (rx_data[7:4])
                                4'h4: begin
                                    to_cnt_d = '0;
                                    state_d  = ST_WAIT_REPLY;
                                    status_d = status_q;
                                end
                                4'h5: begin
                                    state_d  = ST_FIN;
                                    status_d = STATUS_OK;
                                end
                                4'h6:    rx_err_d = 1'b1;
                                default: rx_pos_d = (rx_data == BYTE_TERM) ? RX_HDR : RX_SKIP;
                            endcase
                        end
                        RX_TAIL: begin
                            if (rx_data == BYTE_TERM) begin
                                rx_pos_d = RX_HDR;
                                if (rx_err_q) begin
                                    state_d  = ST_FIN;
                                    status_d = STATUS_ERR;
                                end
                            end
                        end
                        default: begin
                            if (rx_data == BYTE_TERM)
                                rx_pos_d = RX_HDR;
                        end
                    endcase
                end
            end
`endif
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            cmd_q    <= 3'd0;
            spd_q    <= 3'd0;
            status_q <= STATUS_OK;
`ifdef VISCA_REPLY_WAIT_EN
            to_cnt_q <= '0;
            rx_pos_q <= RX_HDR;
            rx_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q  <= state_d;
            idx_q    <= idx_d;
            cmd_q    <= cmd_d;
            spd_q    <= spd_d;
            status_q <= status_d;
`ifdef VISCA_REPLY_WAIT_EN
            to_cnt_q <= to_cnt_d;
            rx_pos_q <= rx_pos_d;
            rx_err_q <= rx_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_visca_cmd_seq.sv
// Directed self-checking bench for visca_cmd_seq (CAM_ADDR 1 and 3 instances).
module tb_visca_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_valid3;
    logic [2:0] cmd_id;
    logic [3:0] cmd_speed;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic       cmd_ready, tx_valid, busy, done;
    logic [7:0] tx_data;
    logic [1:0] status;
    logic       cmd_ready3, tx_valid3, busy3, done3;
    logic [7:0] tx_data3;
    logic [1:0] status3;

    int         n_vec = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         done3_cnt = 0;
    logic [1:0] last_status = 2'd3;
    logic [1:0] last_status3 = 2'd3;

    always #5 clk = ~clk;

    visca_cmd_seq #(.CAM_ADDR(1), .TIMEOUT_CYC(100), .TO_W(25)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_speed(cmd_speed), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .done(done), .status(status)
    );

    visca_cmd_seq #(.CAM_ADDR(3), .TIMEOUT_CYC(100), .TO_W(25)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_id(cmd_id), .cmd_speed(cmd_speed), .tx_data(tx_data3),
        .tx_valid(tx_valid3), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy3), .done(done3), .status(status3)
    );

    // Count done pulses and remember their status, sampled mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            last_status = status;
        end
        if (done3 === 1'b1) begin
            done3_cnt++;
            last_status3 = status3;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    // Present a command for one cycle, then scramble the inputs.
    task automatic issue(input logic [2:0] id, input logic [3:0] spd, input string tag);
        cmd_id    = id;
        cmd_speed = spd;
        cmd_valid = 1'b1;
        check({tag, " ready before accept"}, cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        cmd_id    = ~id;
        cmd_speed = ~spd;
        check({tag, " busy after accept"}, busy, 1);
        check({tag, " cmd_ready after accept"}, cmd_ready, 0);
    endtask

    // Receive the six packet bytes; stall cycles with tx_ready low before each.
    task automatic send_pkt(input logic [47:0] pkt, input int stall, input string tag);
        logic [7:0] exp_b;
        for (int i = 0; i < 6; i++) begin
            exp_b = pkt[47-8*i -: 8];
            if (i > 0 && tx_valid !== 1'b1) step();
            check($sformatf("%s byte%0d valid", tag, i), tx_valid, 1);
            check($sformatf("%s byte%0d data", tag, i), tx_data, exp_b);
            for (int w = 0; w < stall; w++) begin
                tx_ready = 1'b0;
                step();
                check($sformatf("%s byte%0d stall%0d data", tag, i, w), tx_data, exp_b);
                check($sformatf("%s byte%0d stall%0d valid", tag, i, w), tx_valid, 1);
            end
            tx_ready = 1'b1;
            step();
        end
    endtask

    // Completion of a dut command (called right after the last handshake).
    task automatic finish_ok(input string tag);
        int d0;
        d0 = done_cnt;
        check({tag, " tx_valid drops"}, tx_valid, 0);
`ifdef VISCA_REPLY_WAIT_EN
        check({tag, " waiting, no done"}, done, 0);
        send_rx(8'h90);
        send_rx(8'h51);
        send_rx(8'hFF);
        step();
        check({tag, " one done"}, done_cnt - d0, 1);
        check({tag, " status"}, last_status, 0);
`else
        check({tag, " done pulse"}, done, 1);
        check({tag, " status"}, status, 0);
        step();
        check({tag, " done one cycle"}, done, 0);
        check({tag, " one done"}, done_cnt - d0, 1);
`endif
        check({tag, " ready again"}, cmd_ready, 1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            step();
            rx_valid = 1'b0;
            n++;
        end
    endtask

    initial begin
        int hs;
        int n;
        int d0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_id = 3'd0;
        cmd_speed = 4'd0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        step();
        step();
        check("reset cmd_ready", cmd_ready, 1);
        check("reset tx_valid", tx_valid, 0);
        check("reset tx_data", tx_data, 8'h00);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset status", status, 0);
        rst = 1'b0;
        tx_ready = 1'b1;
        step();
        check("idle tx_ready ignored valid", tx_valid, 0);
        check("idle tx_ready ignored ready", cmd_ready, 1);

        // Zoom tele, tx_ready tied high.
        issue(3'd1, 4'd0, "tele");
        send_pkt(48'h81_01_04_07_02_FF, 0, "tele");
        finish_ok("tele");

        // Variable tele, speed 12 clamps to 7, ready high every third cycle.
        issue(3'd3, 4'd12, "tele_var");
        send_pkt(48'h81_01_04_07_27_FF, 2, "tele_var");
        finish_ok("tele_var");

        // Variable wide, speed 5 passes through.
        issue(3'd4, 4'd5, "wide_var");
        send_pkt(48'h81_01_04_07_35_FF, 1, "wide_var");
        finish_ok("wide_var");

        issue(3'd5, 4'd9, "focus_stop");
        send_pkt(48'h81_01_04_08_00_FF, 0, "focus_stop");
        finish_ok("focus_stop");

        issue(3'd2, 4'd0, "zoom_wide");
        send_pkt(48'h81_01_04_07_03_FF, 0, "zoom_wide");
        finish_ok("zoom_wide");

        // Address 3 instance, focus near; cmd_valid held while busy.
        cmd_id = 3'd7; cmd_speed = 4'd0; cmd_valid3 = 1'b1; tx_ready = 1'b1;
        check("addr3 ready", cmd_ready3, 1);
        step();
        cmd_id = 3'd0;
        for (int i = 0; i < 6; i++) begin
            logic [47:0] p3;
            p3 = 48'h83_01_04_08_03_FF;
            if (i > 0 && tx_valid3 !== 1'b1) step();
            if (i == 5) cmd_valid3 = 1'b0;
            check($sformatf("addr3 busy not ready byte%0d", i), cmd_ready3, 0);
            check($sformatf("addr3 byte%0d data", i), tx_data3, p3[47-8*i -: 8]);
            step();
        end
`ifdef VISCA_REPLY_WAIT_EN
        send_rx(8'hB0);
        send_rx(8'h51);
        send_rx(8'hFF);
        step();
        check("addr3 status", last_status3, 0);
`else
        check("addr3 done pulse", done3, 1);
        step();
`endif
        check("addr3 single done", done3_cnt, 1);
        check("addr3 ready again", cmd_ready3, 1);

        // Reset after byte 2 handshake aborts the packet.
        d0 = done_cnt;
        issue(3'd2, 4'd0, "abort");
        tx_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 10 && hs < 3; c++) begin
            if (tx_valid === 1'b1) hs++;
            step();
        end
        check("abort handshakes", hs, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort tx_valid", tx_valid, 0);
        check("abort cmd_ready", cmd_ready, 1);
        check("abort no done", done, 0);
        step();
        step();
        check("abort no done count", done_cnt - d0, 0);
        issue(3'd0, 4'd0, "restart");
        send_pkt(48'h81_01_04_07_00_FF, 0, "restart");
        finish_ok("restart");

`ifdef VISCA_REPLY_WAIT_EN
        // Wrong-header frame and ACK before completion.
        issue(3'd1, 4'd0, "ack");
        send_pkt(48'h81_01_04_07_02_FF, 0, "ack");
        d0 = done_cnt;
        send_rx(8'h91); send_rx(8'h51); send_rx(8'hFF);
        send_rx(8'h90); send_rx(8'h41); send_rx(8'hFF);
        step();
        check("ack no done", done_cnt - d0, 0);
        check("ack still busy", busy, 1);
        finish_ok("ack");

        // Error reply, ACK byte inside the frame ignored.
        issue(3'd6, 4'd0, "err");
        send_pkt(48'h81_01_04_08_02_FF, 0, "err");
        d0 = done_cnt;
        send_rx(8'h90); send_rx(8'h61); send_rx(8'h41);
        check("err no done before FF", done_cnt - d0, 0);
        send_rx(8'hFF);
        step();
        check("err one done", done_cnt - d0, 1);
        check("err status", last_status, 1);

        // Timeout with no reply.
        issue(3'd0, 4'd0, "timeout");
        send_pkt(48'h81_01_04_07_00_FF, 0, "timeout");
        wait_done(n);
        check("timeout cycles", n, 100);
        check("timeout status", status, 2);
        step();
        check("timeout ready again", cmd_ready, 1);

        // ACK restarts the timeout.
        issue(3'd0, 4'd0, "ack_restart");
        send_pkt(48'h81_01_04_07_00_FF, 0, "ack_restart");
        for (int c = 0; c < 50; c++) step();
        send_rx(8'h90);
        send_rx(8'h41);
        rx_data = 8'hFF;
        rx_valid = 1'b1;
        wait_done(n);
        check("ack_restart cycles", n, 100);
        check("ack_restart status", status, 2);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
